// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants and the hex-to-segment table.
//   SEG_OFF  - all segments dark (active-low bus)
//   HEX2SEG  - 16-entry nibble -> {g,f,e,d,c,b,a} table, active-low
//   hex2seg  - table lookup helper
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX2SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> active-low 7-segment pattern.
//   nib_i  in   4  hex nibble
//   seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed N-digit 7-segment driver with double-buffered data.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scan enable
//   load_i       capture digits_i/dp_i/blank_i into the pending buffer
//   digits_i     hex nibbles, digit 0 in bits [3:0]
//   dp_i         decimal point per digit, 1 = lit
//   blank_i      force digit dark, 1 = blank
//   lz_blank_i   leading-zero suppression enable (live)
//   seg_o        segments {g,f,e,d,c,b,a}, active-low
//   dp_o         decimal point, active-low
//   an_o         digit anodes, active-low
//   frame_o      one-cycle pulse at each scan wrap
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_blank_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NW = 4 * NUM_DIGITS;

    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NW-1:0]         pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                  pend_v_q, pend_v_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  tc, boundary, show, lit, zero_run;
    logic [NUM_DIGITS-1:0] lz_mask, dark_vec;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;

    seg7_hex_decode u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        tc        = en && (div_cnt_q == DW'(REFRESH_DIV - 1));
        boundary  = tc && (idx_q == IW'(NUM_DIGITS - 1));
        div_cnt_d = !en ? div_cnt_q : (tc ? '0 : div_cnt_q + 1'b1);
        idx_d     = !tc ? idx_q : (boundary ? '0 : idx_q + 1'b1);
    end

    // A load landing on the boundary bypasses pending so the new frame starts
    // with it; any boundary leaves nothing pending.
    always_comb begin
        pend_digits_d = load_i ? digits_i : pend_digits_q;
        pend_dp_d     = load_i ? dp_i     : pend_dp_q;
        pend_blank_d  = load_i ? blank_i  : pend_blank_q;
        pend_v_d      = !boundary && (load_i || pend_v_q);
        act_digits_d  = (boundary && load_i) ? digits_i :
                        (boundary && pend_v_q) ? pend_digits_q : act_digits_q;
        act_dp_d      = (boundary && load_i) ? dp_i :
                        (boundary && pend_v_q) ? pend_dp_q : act_dp_q;
        act_blank_d   = (boundary && load_i) ? blank_i :
                        (boundary && pend_v_q) ? pend_blank_q : act_blank_q;
    end

    // Walk from the most significant digit down; the run of zeros stays alive
    // only while every higher nibble is zero. Digit 0 is never included.
    always_comb begin
        lz_mask  = '0;
        zero_run = lz_blank_i;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (act_digits_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib  = act_digits_q[{idx_q, 2'b00} +: 4];
        dark_vec = act_blank_q | lz_mask;
        show     = en && !dark_vec[idx_q];
        lit      = show && (div_cnt_q >= DW'(GHOST_CYC));
        an_d     = ~(NUM_DIGITS'(lit) << idx_q);
        seg_d    = show ? cur_seg : SEG_OFF;
        dp_d     = show ? ~act_dp_q[idx_q] : 1'b1;
        frame_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_v_q      <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_q       <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_v_q      <= pend_v_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_q       <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed self-checking bench for seg7_scan_mux (4 digits, 8-cycle slots, 2 ghost cycles).
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_i = 1'b0;
    logic        lz_blank_i = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] LZ_PAT   [4] = '{16'h0005, 16'h0000, 16'h0105, 16'h0105};
    localparam logic        LZ_EN    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [3:0]  LZ_BLANK [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    localparam logic [3:0]  LZ_LIT   [4] = '{4'b0001, 4'b0001, 4'b0111, 4'b1101};
    localparam logic [27:0] LZ_SEG   [4] = '{
        {7'h7F, 7'h7F, 7'h7F, 7'h12},
        {7'h7F, 7'h7F, 7'h7F, 7'h40},
        {7'h7F, 7'h79, 7'h40, 7'h12},
        {7'h40, 7'h79, 7'h7F, 7'h12}
    };

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .GHOST_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_i     (load_i),
        .digits_i   (digits_i),
        .dp_i       (dp_i),
        .blank_i    (blank_i),
        .lz_blank_i (lz_blank_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = frame_o;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        int c, d;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: an=%h seg=%h dp=%b frame=%b, required an=f seg=7f dp=1 frame=0", an_o, seg_o, dp_o, frame_o);
        end
        for (int pass = 0; pass < 2; pass++) begin
            rst_n = 1'b1;
            en = 1'b1;
            for (int k = 0; k < 11; k++) begin
                @(negedge clk);
                d = k / 8;
                c = k % 8;
                ea = (c >= 2) ? ~(4'b0001 << d) : 4'hF;
                checks++;
                if (an_o !== ea || frame_o !== 1'b0 || (c >= 2 && seg_o !== 7'h40)) begin
                    errors++;
                    $display("FAIL reset_first_slot pass=%0d k=%0d: an=%b seg=%h frame=%b, required an=%b seg=40 frame=0", pass, k, an_o, seg_o, frame_o, ea);
                end
            end
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_async pass=%0d: an=%h seg=%h dp=%b frame=%b, required an=f seg=7f dp=1 frame=0", pass, an_o, seg_o, dp_o, frame_o);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [27:0] es = {7'h79, 7'h24, 7'h08, 7'h0E};
        logic [3:0]  dpv = 4'b0100;
        logic [3:0]  ea;
        bit ok;
        int c, d;
        digits_i = 16'h12AF;
        dp_i = dpv;
        blank_i = '0;
        lz_blank_i = 1'b0;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL scan_frame: frame_o=0 after 100 cycles, required a pulse");
        end
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            d = s / 8;
            c = s % 8;
            ea = (c >= 2) ? ~(4'b0001 << d) : 4'hF;
            checks++;
            if (an_o !== ea || frame_o !== (s == 31)) begin
                errors++;
                $display("FAIL scan_an s=%0d: an=%b frame=%b, required an=%b frame=%b", s, an_o, frame_o, ea, s == 31);
            end
            if (c >= 2) begin
                checks++;
                if (seg_o !== es[7*d +: 7] || dp_o !== ~dpv[d]) begin
                    errors++;
                    $display("FAIL scan_seg s=%0d: seg=%h dp=%b, required seg=%h dp=%b", s, seg_o, dp_o, es[7*d +: 7], ~dpv[d]);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [3:0] ea;
        logic [6:0] es;
        bit ok;
        int c, d;
        for (int p = 0; p < 4; p++) begin
            digits_i = LZ_PAT[p];
            dp_i = '0;
            blank_i = LZ_BLANK[p];
            lz_blank_i = LZ_EN[p];
            load_i = 1'b1;
            @(negedge clk);
            load_i = 1'b0;
            wait_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lz_frame p=%0d: frame_o=0 after 100 cycles, required a pulse", p);
            end
            for (int s = 0; s < 32; s++) begin
                @(negedge clk);
                d = s / 8;
                c = s % 8;
                ea = (c >= 2 && LZ_LIT[p][d]) ? ~(4'b0001 << d) : 4'hF;
                es = LZ_SEG[p][7*d +: 7];
                checks++;
                if (an_o !== ea || (c >= 2 && (seg_o !== es || dp_o !== 1'b1))) begin
                    errors++;
                    $display("FAIL lz p=%0d s=%0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=1", p, s, an_o, seg_o, dp_o, ea, es);
                end
            end
        end
        lz_blank_i = 1'b0;
        blank_i = '0;
    endtask

    task automatic test_double_buf();
        logic [3:0] ea;
        bit ok;
        bit seen;
        int c, d;
        digits_i = 16'h8888;
        dp_i = '0;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        wait_frame(ok);
        seen = 1'b0;
        for (int s = 0; s < 40 && !seen; s++) begin
            @(negedge clk);
            seen = frame_o;
            if (an_o !== 4'hF) begin
                checks++;
                if (seg_o !== 7'h00) begin
                    errors++;
                    $display("FAIL dbuf_old s=%0d: seg=%h, required seg=00", s, seg_o);
                end
            end
            if (s == 4) begin
                digits_i = 16'h1111;
                load_i = 1'b1;
            end else if (s == 9) begin
                digits_i = 16'h2222;
                load_i = 1'b1;
            end else begin
                load_i = 1'b0;
            end
        end
        load_i = 1'b0;
        checks++;
        if (!ok || !seen) begin
            errors++;
            $display("FAIL dbuf_frame: frame seen=%b/%b, required 1/1", ok, seen);
        end
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            d = s / 8;
            c = s % 8;
            ea = (c >= 2) ? ~(4'b0001 << d) : 4'hF;
            checks++;
            if (an_o !== ea || (c >= 2 && seg_o !== 7'h24)) begin
                errors++;
                $display("FAIL dbuf_new s=%0d: an=%b seg=%h, required an=%b seg=24", s, an_o, seg_o, ea);
            end
        end
    endtask

    task automatic test_en();
        logic [3:0] exp_an [6] = '{4'b1101, 4'b1101, 4'b1101, 4'hF, 4'hF, 4'b1011};
        bit ok;
        wait_frame(ok);
        repeat (13) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0 || !ok) begin
                errors++;
                $display("FAIL en_off k=%0d: an=%h seg=%h dp=%b frame=%b, required an=f seg=7f dp=1 frame=0", k, an_o, seg_o, dp_o, frame_o);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an[k] || (exp_an[k] !== 4'hF && seg_o !== 7'h24)) begin
                errors++;
                $display("FAIL en_resume k=%0d: an=%b seg=%h, required an=%b seg=24", k, an_o, seg_o, exp_an[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [27:0] es = {7'h03, 7'h06, 7'h06, 7'h0E};
        logic [3:0]  ea;
        bit ok;
        int c, d;
        wait_frame(ok);
        repeat (31) @(negedge clk);
        digits_i = 16'hBEEF;
        dp_i = '0;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        checks++;
        if (frame_o !== 1'b1 || !ok || dut.pend_v_q !== 1'b0) begin
            errors++;
            $display("FAIL bypass_boundary: frame=%b pend_v=%b, required frame=1 pend_v=0", frame_o, dut.pend_v_q);
        end
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            d = s / 8;
            c = s % 8;
            ea = (c >= 2) ? ~(4'b0001 << d) : 4'hF;
            checks++;
            if (an_o !== ea || (c >= 2 && seg_o !== es[7*d +: 7])) begin
                errors++;
                $display("FAIL bypass s=%0d: an=%b seg=%h, required an=%b seg=%h", s, an_o, seg_o, ea, es[7*d +: 7]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_double_buf();
        test_en();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
